uart_tx_ctrl: RTL

- Frame sequencer for the UART transmitter: accepts a parallel word, drives the serializer's load/shift controls, computes parity, and muxes start/data/parity/stop onto the TX line.
- Sits between the host-side byte interface and the serializer datapath. CLK is the baud-rate clock: one bit period per CLK cycle.

---
 rtl/uart_tx_ctrl_pkg.sv | 16 +
 rtl/uart_parity_calc.sv | 27 ++
 rtl/uart_tx_ctrl.sv | 97 +++++++++
 3 files changed

// File: rtl/uart_tx_ctrl_pkg.sv
// Shared definitions for the UART transmit frame sequencer: FSM state
// encoding and parity-type constants.
package uart_tx_ctrl_pkg;

  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    START  = 3'd1,
    DATA   = 3'd2,
    PARITY = 3'd3,
    STOP   = 3'd4
  } tx_state_t;

  localparam logic EVEN = 1'b0;
  localparam logic ODD  = 1'b1;

endpackage

// File: rtl/uart_parity_calc.sv
// Combinational parity of a data word with even/odd selection; the controller
// registers the result at accept time.
module uart_parity_calc
  import uart_tx_ctrl_pkg::*;
#(
  parameter int data_width = 8
) (
  input  logic [data_width-1:0] data,
  input  logic                  par_typ,
  output logic                  parity
);

  logic [data_width-1:0] xor_chain;

  assign xor_chain[0] = data[0];

  genvar gi;
  generate
    for (gi = 1; gi < data_width; gi++) begin : g_xor
      assign xor_chain[gi] = xor_chain[gi-1] ^ data[gi];
    end
  endgenerate

  // Odd parity inverts the even result so the total count of ones is odd.
  assign parity = xor_chain[data_width-1] ^ (par_typ == ODD);

endmodule

// File: rtl/uart_tx_ctrl.sv
// UART transmit frame sequencer: drives serializer load/shift, latches parity
// at accept, and produces a registered start/data/parity/stop line.
module uart_tx_ctrl
  import uart_tx_ctrl_pkg::*;
#(
  parameter int data_width = 8
) (
  input  logic                  CLK,
  input  logic                  RST,
  input  logic [data_width-1:0] P_DATA,
  input  logic                  Data_Valid,
  input  logic                  PAR_EN,
  input  logic                  PAR_TYP,
  input  logic                  ser_data,
  output logic                  ser_load,
  output logic                  ser_en,
  output logic                  TX_OUT,
  output logic                  busy
);

  localparam int CNT_W = $clog2(data_width) + 1;
  localparam logic [CNT_W-1:0] LAST_BIT = CNT_W'(data_width - 1);

  tx_state_t        state_reg;
  logic [CNT_W-1:0] bit_cnt_reg;
  logic             par_en_reg;
  logic             parity_reg;
  logic             parity_next;
  logic             accept;

  // A new word is taken from idle or during the stop bit, giving
  // back-to-back frames with no idle gap.
  assign accept   = Data_Valid && ((state_reg == IDLE) || (state_reg == STOP));
  assign ser_load = accept;
  assign ser_en   = (state_reg == DATA);

  uart_parity_calc #(
    .data_width(data_width)
  ) u_parity (
    .data   (P_DATA),
    .par_typ(PAR_TYP),
    .parity (parity_next)
  );

  // The line register trails the state by one cycle, so each state's bit
  // appears on TX_OUT during the following cycle.
  always_ff @(posedge CLK or negedge RST) begin
    if (!RST) begin
      state_reg   <= IDLE;
      bit_cnt_reg <= '0;
      par_en_reg  <= 1'b0;
      parity_reg  <= 1'b0;
      TX_OUT      <= 1'b1;
      busy        <= 1'b0;
    end else begin
      if (accept) begin
        par_en_reg <= PAR_EN;
        parity_reg <= parity_next;
      end
      case (state_reg)
        IDLE: begin
          TX_OUT <= 1'b1;
          busy   <= 1'b0;
          if (accept) state_reg <= START;
        end
        START: begin
          TX_OUT      <= 1'b0;
          busy        <= 1'b1;
          bit_cnt_reg <= '0;
          state_reg   <= DATA;
        end
        DATA: begin
          TX_OUT      <= ser_data;
          busy        <= 1'b1;
          bit_cnt_reg <= bit_cnt_reg + 1'b1;
          if (bit_cnt_reg == LAST_BIT) state_reg <= par_en_reg ? PARITY : STOP;
        end
        PARITY: begin
          TX_OUT    <= parity_reg;
          busy      <= 1'b1;
          state_reg <= STOP;
        end
        STOP: begin
          TX_OUT    <= 1'b1;
          busy      <= 1'b1;
          state_reg <= accept ? START : IDLE;
        end
        default: begin
          TX_OUT    <= 1'b1;
          busy      <= 1'b0;
          state_reg <= IDLE;
        end
      endcase
    end
  end

endmodule
